// File: rtl/usr_sequencer.sv
// usr_sequencer: command sequencer for a universal shift register (USR).
// Accepts LOAD / SHR / SHL / ROTR commands over valid/ready and drives the
// USR mode, parallel data and serial inputs cycle by cycle, then pulses done.
// Build option: define USR_SEQ_ROTATE_EN to enable rotate-right (op 11).
// Without it, op 11 completes immediately with err=1 and usr_q is unused.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command, USR held
// LOAD  | one parallel-load cycle (usr_mode=11)
// SHIFT | shift/rotate cycles, down-counter runs until the last step
// DONE  | one-cycle done pulse with err, USR held
module usr_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CW-1:0]    cmd_cnt,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_par,
  output logic             usr_sin_r,
  output logic             usr_sin_l,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_SHR   = 2'b01;
  localparam logic [1:0] M_SHL   = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

`ifdef USR_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_clip;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] par_q;
  logic             sin_r_q;
  logic             sin_l_q;
  logic             err_q;

  // Shift counts beyond the register width are meaningless; saturate at WIDTH.
  assign cnt_clip = (cmd_cnt > CW'(WIDTH)) ? CW'(WIDTH) : cmd_cnt;

  // Main sequencer: state, step counter and all registered USR controls.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
      par_q   <= '0;
      sin_r_q <= 1'b0;
      sin_l_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (cmd_valid) begin
            cnt_q <= cnt_clip;
            if (cmd_op == OP_LOAD) begin
              state  <= LOAD;
              mode_q <= M_LOAD;
              par_q  <= cmd_data;
            end else if (cmd_op == OP_ROTR && !ROT_EN) begin
              state <= DONE;
              err_q <= 1'b1;
            end else if (cnt_clip == '0) begin
              state <= DONE;
            end else begin
              state   <= SHIFT;
              mode_q  <= (cmd_op == OP_SHL) ? M_SHL : M_SHR;
              sin_r_q <= (cmd_op == OP_SHR) ? cmd_fill : 1'b0;
              sin_l_q <= (cmd_op == OP_SHL) ? cmd_fill : 1'b0;
            end
          end
        end
        LOAD: begin
          state  <= DONE;
          mode_q <= M_HOLD;
        end
        SHIFT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state   <= DONE;
            mode_q  <= M_HOLD;
            sin_r_q <= 1'b0;
            sin_l_q <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USR_SEQ_ROTATE_EN
  logic rot_q;
  logic unused_usr_q;

  // Remember whether the accepted command is a rotate; its serial input is
  // taken live from the USR LSB rather than from a latched fill bit.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && cmd_valid) begin
      rot_q <= (cmd_op == OP_ROTR);
    end
  end

  assign unused_usr_q = ^usr_q[WIDTH-1:1];
  assign usr_sin_r    = (rot_q && state == SHIFT) ? usr_q[0] : sin_r_q;
`else
  logic unused_usr_q;
  assign unused_usr_q = ^usr_q;
  assign usr_sin_r    = sin_r_q;
`endif

  assign usr_sin_l = sin_l_q;
  assign usr_mode  = mode_q;
  assign usr_par   = par_q;
  assign err       = err_q;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

endmodule

// File: tb/tb_usr_sequencer.sv
// Testbench for usr_sequencer with a behavioural USR model.
// Commands push their expected outcome into a queue; a monitor pops an entry
// on every done pulse and checks latency, mode cycles, err and USR contents.
module tb_usr_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  typedef struct {
    int         lat;
    int         modes;
    logic [1:0] mode;
    logic       err;
    logic [7:0] q;
  } exp_t;

`ifdef USR_SEQ_ROTATE_EN
  localparam logic [7:0] Q_ROT   = 8'h80;
  localparam int         LAT_ROT = 2;
  localparam int         MOD_ROT = 1;
  localparam logic       ERR_ROT = 1'b0;
  localparam logic [7:0] Q_SHL2  = 8'h03;
`else
  localparam logic [7:0] Q_ROT   = 8'h01;
  localparam int         LAT_ROT = 1;
  localparam int         MOD_ROT = 0;
  localparam logic       ERR_ROT = 1'b1;
  localparam logic [7:0] Q_SHL2  = 8'h07;
`endif

  logic          clk = 1'b0;
  logic          clr_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_fill;
  logic [W-1:0]  cmd_data;
  logic [W-1:0]  usr_q;
  logic [1:0]    usr_mode;
  logic [W-1:0]  usr_par;
  logic          usr_sin_r;
  logic          usr_sin_l;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int mode_cnt = 0;
  exp_t exp_q[$];
  int acc_log[$];

  usr_sequencer #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .clr_n(clr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
    .usr_q(usr_q), .usr_mode(usr_mode), .usr_par(usr_par),
    .usr_sin_r(usr_sin_r), .usr_sin_l(usr_sin_l),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural USR: a row of D flip-flops with a 4-way input select.
  initial usr_q = '0;
  always @(posedge clk) begin
    case (usr_mode)
      2'b01:   usr_q <= {usr_sin_r, usr_q[W-1:1]};
      2'b10:   usr_q <= {usr_q[W-2:0], usr_sin_l};
      2'b11:   usr_q <= usr_par;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts cycles, records accepts, checks mode cycles and done pulses.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (usr_mode != 2'b00) begin
      mode_cnt++;
      if (exp_q.size() == 0) chk("mode_without_cmd", {30'd0, usr_mode}, 32'd0);
      else chk("mode_value", {30'd0, usr_mode}, {30'd0, exp_q[0].mode});
      if (usr_mode == 2'b01) chk("sin_l_idle_in_shr", {31'd0, usr_sin_l}, 32'd0);
      if (usr_mode == 2'b10) chk("sin_r_idle_in_shl", {31'd0, usr_sin_r}, 32'd0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_latency", cyc - acc_cyc, e.lat);
        chk("mode_cycles", mode_cnt, e.modes);
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("usr_value", {24'd0, usr_q}, {24'd0, e.q});
      end
    end
    if (clr_n && cmd_valid && cmd_ready) begin
      acc_cyc  = cyc;
      mode_cnt = 0;
      acc_log.push_back(cyc);
    end
  end

  task automatic send(input logic [1:0] op, input logic [CW-1:0] cnt, input logic fill,
                      input logic [7:0] data, input int lat, input int modes,
                      input logic [1:0] mode, input logic e_err, input logic [7:0] q);
    exp_t e;
    int n;
    e.lat = lat; e.modes = modes; e.mode = mode; e.err = e_err; e.q = q;
    exp_q.push_back(e);
    cmd_op = op; cmd_cnt = cnt; cmd_fill = fill; cmd_data = data;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 40);
    if (!cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0; cmd_fill = 1'b0; cmd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", {30'd0, usr_mode}, 32'd0);
    chk("rst_par", {24'd0, usr_par}, 32'd0);
    chk("rst_sin", {30'd0, usr_sin_r, usr_sin_l}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    send(2'b00, 4'd0, 1'b0, 8'hA5, 2, 1, 2'b11, 1'b0, 8'hA5);
    drain();
    send(2'b01, 4'd3, 1'b1, 8'h00, 4, 3, 2'b01, 1'b0, 8'hF4);
    drain();
    send(2'b00, 4'd0, 1'b0, 8'h81, 2, 1, 2'b11, 1'b0, 8'h81);
    drain();
    send(2'b10, 4'd15, 1'b0, 8'h00, 9, 8, 2'b10, 1'b0, 8'h00);
    drain();
    send(2'b00, 4'd0, 1'b0, 8'h01, 2, 1, 2'b11, 1'b0, 8'h01);
    drain();
    send(2'b11, 4'd1, 1'b0, 8'h00, LAT_ROT, MOD_ROT, 2'b01, ERR_ROT, Q_ROT);
    drain();
    send(2'b01, 4'd0, 1'b1, 8'h00, 1, 0, 2'b01, 1'b0, Q_ROT);
    drain();
    chk("par_held", {24'd0, usr_par}, 32'h01);

    // Back-pressure: LOAD presented while SHL is running waits for ready.
    acc_log.delete();
    send(2'b10, 4'd2, 1'b1, 8'h00, 3, 2, 2'b10, 1'b0, Q_SHL2);
    send(2'b00, 4'd0, 1'b0, 8'h3C, 2, 1, 2'b11, 1'b0, 8'h3C);
    drain();
    if (acc_log.size() == 2) chk("backpressure_gap", acc_log[1] - acc_log[0], 4);
    else chk("backpressure_accepts", acc_log.size(), 2);

    // Reset in the second cycle of an 8-step shift aborts with no done.
    send(2'b01, 4'd8, 1'b0, 8'h00, 9, 8, 2'b01, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_mode", {30'd0, usr_mode}, 32'd0);
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_par", {24'd0, usr_par}, 32'd0);
    chk("abort_usr_value", {24'd0, usr_q}, 32'h1E);
    repeat (12) @(posedge clk);
    #1;
    send(2'b00, 4'd0, 1'b0, 8'h5A, 2, 1, 2'b11, 1'b0, 8'h5A);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
